multicycle_ctrl: RTL

//  Multi-cycle control FSM for the RV32I core. Sequences one shared ALU and one

---
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control and memory-handshake bundle between the multicycle controller
// and the datapath / shared memory port.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             memwrite;
  logic             adrsrc;
  logic             irwrite;
  logic             pcwrite;
  logic             regwrite;
  logic [1:0]       resultsrc;
  logic [1:0]       alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       immsrc;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
    output resultsrc, alusrca, alusrcb, aluop, immsrc, illegal, bus_err, instret
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
    input  resultsrc, alusrca, alusrcb, aluop, immsrc, illegal, bus_err, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM (lw/sw/R-type/beq) sharing one ALU and one
// memory port, with memory timeout detection and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BEQ      = 4'd8;
  localparam logic [3:0] ILLEGAL  = 4'd9;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  logic [3:0]       state_q, state_d;
  logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic memReq, accessDone, timeout, retire, pcUpdate, branch;

  always_comb begin
    memReq     = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
    accessDone = memReq && bus.mem_ready;
    timeout    = memReq && !bus.mem_ready && (tmoCnt_q == TMO_W'(MEM_TIMEOUT - 1));
  end

  // A timeout overrides whatever the state wanted: back to FETCH, nothing retires.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      FETCH:    if (accessDone) state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_BEQ:       state_d = BEQ;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        if (bus.op == OP_LW)      state_d = MEMREAD;
        else if (bus.op == OP_SW) state_d = MEMWRITE;
        else                      state_d = ILLEGAL;
      end
      MEMREAD:  if (accessDone) state_d = MEMWB;
      MEMWB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      MEMWRITE: begin
        if (accessDone) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      EXECR:    state_d = ALUWB;
      ALUWB, BEQ: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      ILLEGAL:  state_d = FETCH;
      default:  state_d = FETCH;
    endcase
    if (timeout) begin
      state_d = FETCH;
      retire  = 1'b0;
    end
  end

  always_comb begin
    if (!memReq || accessDone || timeout) tmoCnt_d = '0;
    else                                  tmoCnt_d = tmoCnt_q + 1'b1;
    instret_d = retire ? instret_q + {{(CNT_W-1){1'b0}}, 1'b1} : instret_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      tmoCnt_q  <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      tmoCnt_q  <= tmoCnt_d;
      instret_q <= instret_d;
    end
  end

  // Ready-qualified strobes are masked by reset so nothing writes while it is held.
  always_comb begin
    bus.memwrite  = 1'b0;
    bus.adrsrc    = 1'b0;
    bus.regwrite  = 1'b0;
    bus.resultsrc = 2'b00;
    bus.alusrca   = 2'b00;
    bus.alusrcb   = 2'b00;
    bus.aluop     = 2'b00;
    bus.illegal   = 1'b0;
    branch        = 1'b0;
    case (state_q)
      FETCH: begin
        bus.alusrcb   = 2'b10;
        bus.resultsrc = 2'b10;
      end
      DECODE: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b01;
      end
      MEMADR: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
      end
      MEMREAD:  bus.adrsrc = 1'b1;
      MEMWB: begin
        bus.resultsrc = 2'b01;
        bus.regwrite  = 1'b1;
      end
      MEMWRITE: begin
        bus.adrsrc   = 1'b1;
        bus.memwrite = 1'b1;
      end
      EXECR: begin
        bus.alusrca = 2'b10;
        bus.aluop   = 2'b10;
      end
      ALUWB:    bus.regwrite = 1'b1;
      BEQ: begin
        bus.alusrca = 2'b10;
        bus.aluop   = 2'b01;
        branch      = 1'b1;
      end
      ILLEGAL:  bus.illegal = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    pcUpdate    = (state_q == FETCH) && accessDone && rst_n;
    bus.mem_req = memReq;
    bus.irwrite = pcUpdate;
    bus.pcwrite = pcUpdate || (branch && bus.zero);
    bus.bus_err = timeout && rst_n;
    bus.instret = instret_q;
    if (bus.op == OP_SW)       bus.immsrc = 2'b01;
    else if (bus.op == OP_BEQ) bus.immsrc = 2'b10;
    else                       bus.immsrc = 2'b00;
  end

endmodule
